// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the adder_arbiter slice: the pipeline tag,
// default geometry, and the width of the inflight counter.
package adder_arb_pkg;

  localparam int DSIZE_DEF = 64;
  localparam int NREQ_DEF  = 4;
  localparam int LAT_DEF   = 2;

  // Tag id is sized for the largest supported requester count (16).
  localparam int MAX_IDW = 4;

  typedef struct packed {
    logic               vld;
    logic [MAX_IDW-1:0] id;
  } tag_t;

  // Counter must hold LAT tag stages plus the optional output stage.
  function automatic int inflight_width(input int lat);
    return $clog2(lat + 2);
  endfunction

endpackage

// File: rtl/adder_arbiter_rr.sv
// Reusable round-robin arbiter: combinational grant searched from the stored
// last grant + 1; the pointer moves only when advance_i reports a transfer.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_i,
  input  logic                    en_i,
  input  logic                    advance_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] grant_id_o
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] last_q, last_d;

  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    found      = 1'b0;
    idx        = '0;
    grant_o    = '0;
    grant_id_o = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_q) + k) % NREQ);
      if (en_i && !found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = idx;
      end
    end
  end

  assign last_d = advance_i ? grant_id_o : last_q;

  // Reset to the top index so requester 0 wins the first search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= IDW'(NREQ - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one LAT-cycle 4-operand adder among NREQ requesters; tags ride
// alongside the adder and steer each sum back. ADDER_ARB_OUTREG_EN adds an output register.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req_valid_i,
  output logic [NREQ-1:0]                 req_ready_o,
  input  logic [NREQ*DSIZE-1:0]           req_a_i,
  input  logic [NREQ*DSIZE-1:0]           req_b_i,
  input  logic [NREQ*DSIZE-1:0]           req_c_i,
  input  logic [NREQ*DSIZE-1:0]           req_d_i,
  input  logic                            cfg_pause_i,
  output logic [DSIZE-1:0]                add_a_o,
  output logic [DSIZE-1:0]                add_b_o,
  output logic [DSIZE-1:0]                add_c_o,
  output logic [DSIZE-1:0]                add_d_o,
  input  logic [DSIZE-1:0]                add_sum_i,
  output logic [NREQ-1:0]                 rsp_valid_o,
  output logic [DSIZE-1:0]                rsp_sum_o,
  output logic [inflight_width(LAT)-1:0]  inflight_o,
  output logic                            idle_o
);

  localparam int IDW = $clog2(NREQ);
  localparam int IFW = inflight_width(LAT);

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gid;
  logic             transfer;
  logic             retire;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_valid_i),
    .en_i       (!cfg_pause_i),
    .advance_i  (transfer),
    .grant_o    (grant),
    .grant_id_o (gid)
  );

  assign req_ready_o = grant;
  assign transfer    = |(req_valid_i & grant);

  logic [DSIZE-1:0] a_arr [NREQ];
  logic [DSIZE-1:0] b_arr [NREQ];
  logic [DSIZE-1:0] c_arr [NREQ];
  logic [DSIZE-1:0] d_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a_i[gi*DSIZE +: DSIZE];
    assign b_arr[gi] = req_b_i[gi*DSIZE +: DSIZE];
    assign c_arr[gi] = req_c_i[gi*DSIZE +: DSIZE];
    assign d_arr[gi] = req_d_i[gi*DSIZE +: DSIZE];
  end

  assign add_a_o = transfer ? a_arr[gid] : '0;
  assign add_b_o = transfer ? b_arr[gid] : '0;
  assign add_c_o = transfer ? c_arr[gid] : '0;
  assign add_d_o = transfer ? d_arr[gid] : '0;

  // Tag pipe mirrors the adder latency exactly; it never stalls.
  tag_t tag_q [LAT];
  tag_t tag_d;
  tag_t tag_last;

  assign tag_d.vld = transfer;
  assign tag_d.id  = MAX_IDW'(gid);
  assign tag_last  = tag_q[LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  logic [NREQ-1:0]  rsp_valid_d;
  logic [DSIZE-1:0] rsp_sum_d;

  always_comb begin
    rsp_valid_d = '0;
    rsp_sum_d   = '0;
    if (tag_last.vld) begin
      rsp_sum_d = add_sum_i;
      for (int r = 0; r < NREQ; r++) rsp_valid_d[r] = (tag_last.id == MAX_IDW'(r));
    end
  end

`ifdef ADDER_ARB_OUTREG_EN
  logic [NREQ-1:0]  rsp_valid_q;
  logic [DSIZE-1:0] rsp_sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign retire      = |rsp_valid_q;
`else
  assign rsp_valid_o = rsp_valid_d;
  assign rsp_sum_o   = rsp_sum_d;
  assign retire      = tag_last.vld;
`endif

  // A request leaves the count in the cycle after its response is presented.
  logic [IFW-1:0] inflight_q, inflight_d;

  assign inflight_d = inflight_q + IFW'(transfer) - IFW'(retire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= '0;
    else        inflight_q <= inflight_d;
  end

  assign inflight_o = inflight_q;
  assign idle_o     = (inflight_q == '0) && !(|req_valid_i);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural LAT-stage adder and a
// scoreboard queue of expected responses; honours ADDER_ARB_OUTREG_EN.
module tb_adder_arbiter;

  localparam int DSIZE = 64;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;
`ifdef ADDER_ARB_OUTREG_EN
  localparam int RLAT  = LAT + 1;
`else
  localparam int RLAT  = LAT;
`endif
  localparam int IFW   = $clog2(LAT + 2);

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DSIZE-1:0]  req_a, req_b, req_c, req_d;
  logic                   cfg_pause;
  logic [DSIZE-1:0]       add_a, add_b, add_c, add_d, add_sum;
  logic [NREQ-1:0]        rsp_valid;
  logic [DSIZE-1:0]       rsp_sum;
  logic [IFW-1:0]         inflight;
  logic                   idle;

  logic [DSIZE-1:0] op_a [NREQ];
  logic [DSIZE-1:0] op_b [NREQ];
  logic [DSIZE-1:0] op_c [NREQ];
  logic [DSIZE-1:0] op_d [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DSIZE +: DSIZE] = op_a[i];
      req_b[i*DSIZE +: DSIZE] = op_b[i];
      req_c[i*DSIZE +: DSIZE] = op_c[i];
      req_d[i*DSIZE +: DSIZE] = op_d[i];
    end
  end

  // Behavioural adder sharing rst_n with the arbiter.
  logic [DSIZE-1:0] sum_pipe [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) sum_pipe[s] <= '0;
    end else begin
      sum_pipe[0] <= add_a + add_b + add_c + add_d;
      for (int s = 1; s < LAT; s++) sum_pipe[s] <= sum_pipe[s-1];
    end
  end
  assign add_sum = sum_pipe[LAT-1];

  adder_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_c_i     (req_c),
    .req_d_i     (req_d),
    .cfg_pause_i (cfg_pause),
    .add_a_o     (add_a),
    .add_b_o     (add_b),
    .add_c_o     (add_c),
    .add_d_o     (add_d),
    .add_sum_i   (add_sum),
    .rsp_valid_o (rsp_valid),
    .rsp_sum_o   (rsp_sum),
    .inflight_o  (inflight),
    .idle_o      (idle)
  );

  typedef struct {
    int               id;
    logic [DSIZE-1:0] sum;
    int               due;
  } exp_t;

  exp_t q[$];
  int   last_m = NREQ - 1;
  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [DSIZE-1:0] a, input logic [DSIZE-1:0] b,
                         input logic [DSIZE-1:0] c, input logic [DSIZE-1:0] d);
    op_a[i] = a; op_b[i] = b; op_c[i] = c; op_d[i] = d;
  endtask

  // One clock: model the arbiter, compare every output at the falling edge,
  // update the scoreboard, then return just after the next rising edge.
  task automatic cycle(input int exp_gnt = -1);
    logic [NREQ-1:0]  g;
    logic [NREQ-1:0]  eg;
    logic [NREQ-1:0]  erv;
    logic [DSIZE-1:0] ers;
    int               gid;
    exp_t             e;
    @(negedge clk);
    g = '0; gid = 0;
    if (!cfg_pause) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (last_m + k) % NREQ;
        if (g == '0 && req_valid[idx]) begin
          g[idx] = 1'b1;
          gid = idx;
        end
      end
    end
    chk("req_ready", 64'(req_ready), 64'(g));
    if (exp_gnt >= 0) begin
      eg = '0;
      eg[exp_gnt] = 1'b1;
      chk("rr_order", 64'(req_ready), 64'(eg));
    end
    chk("add_a", add_a, (g != '0) ? op_a[gid] : '0);
    chk("add_b", add_b, (g != '0) ? op_b[gid] : '0);
    chk("add_c", add_c, (g != '0) ? op_c[gid] : '0);
    chk("add_d", add_d, (g != '0) ? op_d[gid] : '0);
    erv = '0; ers = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      erv[q[0].id] = 1'b1;
      ers = q[0].sum;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(erv));
    chk("rsp_sum", rsp_sum, ers);
    chk("inflight", 64'(inflight), 64'(q.size()));
    chk("idle", 64'(idle), 64'((q.size() == 0) && (req_valid == '0)));
    if (erv != '0) begin
      $display("rsp  cycle=%0d id=%0d sum=%0h", cyc, q[0].id, q[0].sum);
      void'(q.pop_front());
    end
    if (g != '0) begin
      e.id  = gid;
      e.sum = op_a[gid] + op_b[gid] + op_c[gid] + op_d[gid];
      e.due = cyc + RLAT;
      q.push_back(e);
      last_m = gid;
      $display("req  cycle=%0d id=%0d expected_sum=%0h", cyc, gid, e.sum);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    req_valid = '0;
    cfg_pause = 1'b0;
    for (int i = 0; i < NREQ; i++) set_ops(i, '0, '0, '0, '0);

    // Reset state.
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Single requester 2: 1+2+3+4.
    set_ops(2, 64'd1, 64'd2, 64'd3, 64'd4);
    req_valid = 4'b0100;
    cycle(2);
    req_valid = '0;
    repeat (RLAT + 2) cycle();

    // Park the pointer at 3, then full contention for 8 cycles.
    for (int i = 0; i < NREQ; i++)
      set_ops(i, 64'(i + 1), 64'((i + 1) * 16), 64'(100 * i), 64'hF000_0000_0000_0000 + 64'(i));
    req_valid = 4'b1000;
    cycle(3);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) cycle(k % NREQ);
    req_valid = '0;
    repeat (RLAT + 2) cycle();

    // Modulo 2^64 wrap cases.
    set_ops(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    set_ops(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0);
    req_valid = 4'b0001;
    cycle(0);
    req_valid = 4'b0010;
    cycle(1);
    req_valid = '0;
    repeat (RLAT + 2) cycle();

    // Pause: grant to 1, hold 1 and 3 during a 3-cycle pause, then 3 wins.
    set_ops(1, 64'd11, 64'd22, 64'd33, 64'd44);
    set_ops(3, 64'd5, 64'd6, 64'd7, 64'd8);
    req_valid = 4'b0010;
    cycle(1);
    req_valid = 4'b1010;
    cfg_pause = 1'b1;
    repeat (3) cycle();
    cfg_pause = 1'b0;
    cycle(3);
    req_valid = '0;
    repeat (RLAT + 2) cycle();

    // Reset one cycle after two issues: in-flight sums must vanish.
    set_ops(0, 64'd100, 64'd200, 64'd300, 64'd400);
    set_ops(1, 64'd7, 64'd7, 64'd7, 64'd7);
    req_valid = 4'b0011;
    cycle(0);
    cycle(1);
    req_valid = '0;
    rst_n = 1'b0;
    q.delete();
    last_m = NREQ - 1;
    cycle();
    rst_n = 1'b1;
    repeat (RLAT + 3) cycle();

    // Rotation restarts from requester 0 after reset.
    req_valid = 4'b0011;
    cycle(0);
    req_valid = '0;
    repeat (RLAT + 2) cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
